ysyx_25020032_key_lut: RTL and testbench

- Runtime-programmable key-to-data lookup table with NR_KEY entries.
- Each entry holds a valid bit, a key and a data word.
- A lookup request (valid/ready) returns a registered response: data, hit flag and matched index.
- On a miss it returns a programmable default. Saturating hit/miss counters are included.
- Used wherever decode/select tables must be rewritten at run time instead of fixed at elaboration (CSR remap, device address decode).

---
 rtl/ysyx_25020032_key_lut.sv | 117 +++++++++++
 tb/tb_ysyx_25020032_key_lut.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020032_key_lut.sv
// ysyx_25020032_key_lut: runtime-programmable key-to-data lookup table with registered response and hit/miss statistics
module ysyx_25020032_key_lut #(
    parameter int NR_KEY      = 8,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 1,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic                wr_set,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                clr,
    input  logic                def_we,
    input  logic [DATA_LEN-1:0] def_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic [IDX_W-1:0]    rsp_idx,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);
    logic [NR_KEY-1:0]   valid_q, valid_d;
    logic [KEY_LEN-1:0]  key_q [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] def_q, def_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic                accept, wr_ok, m_hit;
    logic [IDX_W-1:0]    m_idx;
    logic [DATA_LEN-1:0] m_data;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wr_ok     = wr_en && !clr && (32'(wr_idx) < NR_KEY);

    // Priority match: scan high to low so the lowest matching index is left standing
    always_comb begin
        m_hit = 1'b0;
        m_idx = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (valid_q[i] && key_q[i] == req_key) begin
                m_hit = 1'b1;
                m_idx = IDX_W'(i);
            end
        end
        m_data = m_hit ? data_q[m_idx] : (HAS_DEFAULT != 0 ? def_q : '0);
    end

    // Table valid bits and default register next state; clr overrides any entry write
    always_comb begin
        valid_d = valid_q;
        if (clr) valid_d = '0;
        else if (wr_ok) valid_d[wr_idx] = wr_set;
        def_d = def_we ? def_data : def_q;
    end

    // Response register and saturating statistics next state
    always_comb begin
        rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);
        rsp_data_d  = accept ? m_data : rsp_data_q;
        rsp_hit_d   = accept ? m_hit : rsp_hit_q;
        rsp_idx_d   = accept ? m_idx : rsp_idx_q;
        hit_cnt_d   = (accept && m_hit && !(&hit_cnt_q)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
        miss_cnt_d  = (accept && !m_hit && !(&miss_cnt_q)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
    end

    // Key/data payload storage, written only on a set of an in-range entry
    always_ff @(posedge clk) begin
        if (wr_ok && wr_set) begin
            key_q[wr_idx]  <= wr_key;
            data_q[wr_idx] <= wr_data;
        end
    end

    // Control and response state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            def_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            def_q       <= def_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_ysyx_25020032_key_lut.sv
// tb_ysyx_25020032_key_lut: scoreboard bench driving a default instance and a CNT_W=2/no-default instance in parallel
module tb_ysyx_25020032_key_lut;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, wr_set, clr, def_we, req_valid, rsp_ready;
    logic [2:0]  wr_idx;
    logic [3:0]  wr_key, req_key;
    logic [31:0] wr_data, def_data;
    logic        req_ready_a, rsp_valid_a, rsp_hit_a;
    logic        req_ready_b, rsp_valid_b, rsp_hit_b;
    logic [31:0] rsp_data_a, rsp_data_b;
    logic [2:0]  rsp_idx_a, rsp_idx_b;
    logic [15:0] hit_cnt_a, miss_cnt_a;
    logic [1:0]  hit_cnt_b, miss_cnt_b;

    typedef struct packed {
        logic [31:0] da;
        logic [31:0] db;
        logic        hit;
        logic [2:0]  idx;
        logic [15:0] ha;
        logic [15:0] ma;
        logic [1:0]  hb;
        logic [1:0]  mb;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_m;
    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] m_ha = 0, m_ma = 0;
    logic [1:0]  m_hb = 0, m_mb = 0;

    always #5 clk = ~clk;

    ysyx_25020032_key_lut ua (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_set(wr_set),
        .wr_key(wr_key), .wr_data(wr_data), .clr(clr), .def_we(def_we), .def_data(def_data),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_key(req_key),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a),
        .rsp_hit(rsp_hit_a), .rsp_idx(rsp_idx_a), .hit_cnt(hit_cnt_a), .miss_cnt(miss_cnt_a)
    );

    ysyx_25020032_key_lut #(.HAS_DEFAULT(0), .CNT_W(2)) ub (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_set(wr_set),
        .wr_key(wr_key), .wr_data(wr_data), .clr(clr), .def_we(def_we), .def_data(def_data),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_key(req_key),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
        .rsp_hit(rsp_hit_b), .rsp_idx(rsp_idx_b), .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one lookup; on acceptance push the hand-given expected response plus running counts
    task automatic do_req(input logic [3:0] k, input logic h, input logic [2:0] ix, input logic [31:0] d);
        int   n = 0;
        exp_t e;
        req_valid = 1'b1;
        req_key   = k;
        @(negedge clk);
        while (!req_ready_a && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready_a) begin
            check("req_accept_timeout", {31'd0, req_ready_a}, 32'd1);
        end else begin
            if (h) begin
                m_ha = m_ha + 16'd1;
                m_hb = (m_hb == 2'd3) ? 2'd3 : m_hb + 2'd1;
            end else begin
                m_ma = m_ma + 16'd1;
                m_mb = (m_mb == 2'd3) ? 2'd3 : m_mb + 2'd1;
            end
            e.da  = d;
            e.db  = h ? d : 32'd0;
            e.hit = h;
            e.idx = ix;
            e.ha  = m_ha;
            e.ma  = m_ma;
            e.hb  = m_hb;
            e.mb  = m_mb;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] ix, input logic s, input logic [3:0] k, input logic [31:0] d);
        wr_en = 1'b1; wr_idx = ix; wr_set = s; wr_key = k; wr_data = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed response is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && rsp_valid_a && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
            end else begin
                e_m = exp_q.pop_front();
                check("rsp_data_a", rsp_data_a, e_m.da);
                check("rsp_hit_a", {31'd0, rsp_hit_a}, {31'd0, e_m.hit});
                check("rsp_idx_a", {29'd0, rsp_idx_a}, {29'd0, e_m.idx});
                check("hit_cnt_a", {16'd0, hit_cnt_a}, {16'd0, e_m.ha});
                check("miss_cnt_a", {16'd0, miss_cnt_a}, {16'd0, e_m.ma});
                check("rsp_valid_b", {31'd0, rsp_valid_b}, 32'd1);
                check("rsp_data_b", rsp_data_b, e_m.db);
                check("rsp_idx_b", {29'd0, rsp_idx_b}, {29'd0, e_m.idx});
                check("hit_cnt_b", {30'd0, hit_cnt_b}, {30'd0, e_m.hb});
                check("miss_cnt_b", {30'd0, miss_cnt_b}, {30'd0, e_m.mb});
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; wr_en = 0; wr_set = 0; wr_idx = 0; wr_key = 0; wr_data = 0;
        clr = 0; def_we = 0; def_data = 0; req_valid = 0; req_key = 0; rsp_ready = 1'b1;
        idle(3);
        rst_n = 1'b1;
        check("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready_a}, 32'd1);
        check("rst_hit_cnt", {16'd0, hit_cnt_a}, 32'd0);
        check("rst_miss_cnt", {16'd0, miss_cnt_a}, 32'd0);
        check("rst_rsp_data", rsp_data_a, 32'd0);

        do_req(4'd3, 1'b0, 3'd0, 32'd0);

        def_we = 1'b1; def_data = 32'hFFFF0000;
        wr(3'd2, 1'b1, 4'd5, 32'hDEADBEEF);
        def_we = 1'b0;
        do_req(4'd5, 1'b1, 3'd2, 32'hDEADBEEF);
        do_req(4'd6, 1'b0, 3'd0, 32'hFFFF0000);

        wr(3'd1, 1'b1, 4'd9, 32'h11);
        wr(3'd6, 1'b1, 4'd9, 32'h66);
        do_req(4'd9, 1'b1, 3'd1, 32'h11);
        wr(3'd1, 1'b0, 4'd0, 32'd0);
        do_req(4'd9, 1'b1, 3'd6, 32'h66);
        idle(2);

        rsp_ready = 1'b0;
        do_req(4'd5, 1'b1, 3'd2, 32'hDEADBEEF);
        req_valid = 1'b1; req_key = 4'd9;
        repeat (4) begin
            @(negedge clk);
            check("hold_req_ready", {31'd0, req_ready_a}, 32'd0);
            check("hold_rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
            check("hold_rsp_data", rsp_data_a, 32'hDEADBEEF);
            check("hold_rsp_idx", {29'd0, rsp_idx_a}, 32'd2);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        do_req(4'd9, 1'b1, 3'd6, 32'h66);
        idle(2);

        clr = 1'b1;
        wr(3'd0, 1'b1, 4'd7, 32'h7);
        clr = 1'b0;
        do_req(4'd7, 1'b0, 3'd0, 32'hFFFF0000);

        wr_en = 1'b1; wr_idx = 3'd3; wr_set = 1'b1; wr_key = 4'd4; wr_data = 32'h44;
        do_req(4'd4, 1'b0, 3'd0, 32'hFFFF0000);
        wr_en = 1'b0;
        do_req(4'd4, 1'b1, 3'd3, 32'h44);

        def_we = 1'b1; def_data = 32'h12345678;
        do_req(4'd6, 1'b0, 3'd0, 32'hFFFF0000);
        def_we = 1'b0;
        do_req(4'd6, 1'b0, 3'd0, 32'h12345678);

        repeat (5) do_req(4'd4, 1'b1, 3'd3, 32'h44);
        idle(2);
        check("sat_hit_cnt_a", {16'd0, hit_cnt_a}, 32'd11);
        check("sat_miss_cnt_a", {16'd0, miss_cnt_a}, 32'd6);
        check("sat_hit_cnt_b", {30'd0, hit_cnt_b}, 32'd3);
        check("sat_miss_cnt_b", {30'd0, miss_cnt_b}, 32'd3);

        rsp_ready = 1'b0;
        do_req(4'd4, 1'b1, 3'd3, 32'h44);
        check("pre_rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid_a", {31'd0, rsp_valid_a}, 32'd0);
        check("async_rst_valid_b", {31'd0, rsp_valid_b}, 32'd0);
        check("async_rst_hit_cnt_a", {16'd0, hit_cnt_a}, 32'd0);
        check("async_rst_miss_cnt_a", {16'd0, miss_cnt_a}, 32'd0);
        check("async_rst_hit_cnt_b", {30'd0, hit_cnt_b}, 32'd0);
        check("async_rst_rsp_data", rsp_data_a, 32'd0);
        exp_q.delete();
        m_ha = 0; m_ma = 0; m_hb = 0; m_mb = 0;
        @(posedge clk);
        #1 rst_n = 1'b1; rsp_ready = 1'b1;
        do_req(4'd4, 1'b0, 3'd0, 32'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        idle(1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
